// File: rtl/lab4_branch_pht_pkg.sv
// Shared types and helpers for the branch PHT scheduler.
package lab4_branch_pht_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } top_state_e;

  typedef enum logic {
    U_IDLE  = 1'b0,
    U_WRITE = 1'b1
  } upd_state_e;

  // Weakly not-taken.
  localparam logic [1:0] INIT_VAL_DEF = 2'b01;

  // 2-bit saturating counter step; never wraps.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/lab4_branch_pht_upd_queue.sv
// Small FIFO holding pending branch-resolution updates.
module lab4_branch_pht_upd_queue
  import lab4_branch_pht_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq_fire;
  logic             pop_fire;

  // Status flags, handshakes and pointer/occupancy next state.
  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH));
    empty    = (cnt_q == '0);
    enq_rdy  = !full;
    enq_fire = enq_val && !full;
    pop_fire = pop && !empty;
    head     = mem_q[rptr_q];
    wptr_d   = enq_fire ? (wptr_q + PTR_W'(1)) : wptr_q;
    rptr_d   = pop_fire ? (rptr_q + PTR_W'(1)) : rptr_q;
    cnt_d    = cnt_q;
    if (enq_fire && !pop_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!enq_fire && pop_fire) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset discards all entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless once the count says empty.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wptr_q] <= enq_data;
  end

endmodule

// File: rtl/lab4_branch_pht_sched.sv
// Owns the PHT read/write ports: init sweep, lookup/update arbitration, update RMW.
module lab4_branch_pht_sched
  import lab4_branch_pht_pkg::*;
#(
  parameter int unsigned PHT_SIZE  = 2048,
  parameter int unsigned UPD_DEPTH = 4,
  parameter logic [1:0]  INIT_VAL  = INIT_VAL_DEF,
  localparam int unsigned IDX_W    = $clog2(PHT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_val,
  output logic             pred_rdy,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  input  logic             upd_val,
  output logic             upd_rdy,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  output logic [IDX_W-1:0] pht_raddr,
  input  logic [1:0]       pht_rdata,
  output logic             pht_wen,
  output logic [IDX_W-1:0] pht_waddr,
  output logic [1:0]       pht_wdata,
  output logic             init_done
);

  localparam int unsigned ENT_W = IDX_W + 1;

  top_state_e       top_q, top_d;
  upd_state_e       ust_q, ust_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]       wr_ctr_q, wr_ctr_d;
  logic             wr_tkn_q, wr_tkn_d;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [ENT_W-1:0] q_head;
  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;
  logic             q_full;
  logic             q_empty;
  logic             q_pop;
  logic             upd_gnt;
  logic             pred_gnt;
  logic [1:0]       wr_val;
  logic             unused_pc;

  assign pred_idx  = pred_pc[IDX_W+1:2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign head_idx  = q_head[ENT_W-1:1];
  assign head_tkn  = q_head[0];
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

  lab4_branch_pht_upd_queue #(
    .WIDTH (ENT_W),
    .DEPTH (UPD_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (upd_val),
    .enq_rdy  (upd_rdy),
    .enq_data ({upd_idx, upd_taken}),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Next-state logic for both FSMs, read-port arbiter and write-port mux.
  always_comb begin
    top_d      = top_q;
    ust_d      = ust_q;
    sweep_d    = sweep_q;
    wr_idx_d   = wr_idx_q;
    wr_ctr_d   = wr_ctr_q;
    wr_tkn_d   = wr_tkn_q;
    q_pop      = 1'b0;
    upd_gnt    = 1'b0;
    pred_gnt   = 1'b0;
    pred_taken = 1'b0;
    wr_val     = sat_update(wr_ctr_q, wr_tkn_q);
    pht_raddr  = pred_idx;
    pht_wen    = 1'b0;
    pht_waddr  = wr_idx_q;
    pht_wdata  = wr_val;
    init_done  = (top_q == ST_RUN);
    pred_rdy   = init_done && !q_full;

    case (top_q)
      ST_INIT: begin
        pht_wen   = 1'b1;
        pht_waddr = sweep_q;
        pht_wdata = INIT_VAL;
        sweep_d   = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(PHT_SIZE - 1)) top_d = ST_RUN;
      end
      ST_RUN: begin
        // Updates only preempt lookups once the queue is full.
        upd_gnt  = !q_empty && (q_full || !pred_val);
        pred_gnt = pred_val && pred_rdy;
        if (ust_q == U_WRITE) pht_wen = 1'b1;
        if (upd_gnt) begin
          pht_raddr = head_idx;
          q_pop     = 1'b1;
          wr_idx_d  = head_idx;
          wr_tkn_d  = head_tkn;
          // Same-index write in flight: the array still holds the stale value.
          wr_ctr_d  = ((ust_q == U_WRITE) && (wr_idx_q == head_idx)) ? wr_val : pht_rdata;
          ust_d     = U_WRITE;
        end else begin
          ust_d = U_IDLE;
        end
        if (pred_gnt) pred_taken = pht_rdata[1];
      end
      default: top_d = ST_INIT;
    endcase

    if (reset) pht_wen = 1'b0;
  end

  // State registers; reset aborts the sweep and any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q    <= ST_INIT;
      ust_q    <= U_IDLE;
      sweep_q  <= '0;
      wr_idx_q <= '0;
      wr_ctr_q <= '0;
      wr_tkn_q <= 1'b0;
    end else begin
      top_q    <= top_d;
      ust_q    <= ust_d;
      sweep_q  <= sweep_d;
      wr_idx_q <= wr_idx_d;
      wr_ctr_q <= wr_ctr_d;
      wr_tkn_q <= wr_tkn_d;
    end
  end

endmodule

// File: doc/lab4_branch_pht_sched.md
# lab4_branch_pht_sched

Scheduler that owns the single read port and single write port of a bimodal pattern history table (PHT) of 2-bit saturating counters. It sequences a post-reset table-initialisation sweep, arbitrates the read port between front-end prediction lookups and queued branch-resolution updates, and performs each update as a two-cycle read-modify-write. It sits between fetch/resolve logic and a `vc_Regfile_1r1w`-style PHT array, which is external to this block.

## Interface
- `PHT_SIZE`, 2048: number of PHT entries, power of two.
- `UPD_DEPTH`, 4: update queue entries, power of two, at least 2.
- `INIT_VAL`, 2'b01: counter value written during the init sweep (weakly not-taken).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `pred_val` in 1: prediction lookup request.
- `pred_rdy` out 1: lookup accepted this cycle.
- `pred_pc` in 32: lookup PC.
- `pred_taken` out 1: prediction; valid in the cycle where `pred_val && pred_rdy`.
- `upd_val` in 1: resolved-branch update request.
- `upd_rdy` out 1: update queue can accept.
- `upd_pc` in 32: resolved branch PC.
- `upd_taken` in 1: resolved direction.
- `pht_raddr` out log2(PHT_SIZE): PHT read address.
- `pht_rdata` in 2: PHT combinational read data.
- `pht_wen` out 1: PHT write enable.
- `pht_waddr` out log2(PHT_SIZE): PHT write address.
- `pht_wdata` out 2: PHT write data.
- `init_done` out 1: init sweep complete.

## Operation
- Index is `pc[log2(PHT_SIZE)+1:2]` for both lookups and updates.
- The top FSM has two states: INIT and RUN. Reset enters INIT with sweep counter 0.
- INIT behaviour:
  - `pht_wen=1`, `pht_waddr`=counter, `pht_wdata=INIT_VAL`. The counter increments each cycle.
  - After writing entry PHT_SIZE-1, the FSM goes to RUN and sets `init_done=1`.
  - `pred_rdy=0` throughout INIT.
  - Updates may be enqueued, but nothing drains until RUN.
- The update queue is a FIFO of {index, taken}. `upd_rdy = !full`. Enqueue and dequeue in the same cycle are allowed. There is no pass-through when full.
- The update FSM (in RUN) has two states: U_IDLE and U_WRITE.
  - U_IDLE: if the queue is non-empty and the update is granted the read port, drive `pht_raddr`=head index. Capture the counter and taken bit, pop the head, and go to U_WRITE.
  - U_WRITE: `pht_wen=1`, `pht_waddr`=captured index, `pht_wdata`=sat(captured counter, taken). Another update read may be granted in the same cycle (back-to-back); otherwise return to U_IDLE.
- Saturating update: taken gives min(c+1, 3); not-taken gives max(c-1, 0). 2-bit arithmetic, never wraps.
- Read-port arbitration (RUN):
  - The update wins only when the queue is full.
  - Otherwise a lookup wins if `pred_val=1`.
  - Otherwise the update uses the idle port.
  - `pred_rdy = init_done && !full`.
- Forwarding: if an update read hits the index being written in the same cycle, it uses `pht_wdata` instead of `pht_rdata`. Lookups are not forwarded; they see the pre-write value.
- `pred_taken = pht_rdata[1]` when the lookup owns the port.

## Timing
- Reset values:
  - State INIT, counter 0, queue empty, U_IDLE.
  - `pred_rdy=0`, `upd_rdy=1`, `init_done=0`.
  - `pht_wen=0` while `reset` is asserted.
- Init sweep takes exactly PHT_SIZE cycles after reset deasserts. `init_done` rises in cycle PHT_SIZE.
- Lookups have zero latency: `pred_taken` is combinational in the handshake cycle.
- Update timeline, with an uncontended port:
  - Handshake in cycle 0.
  - Read in cycle 1.
  - Write in cycle 2.
  - A lookup in cycle 3 observes the new counter.
- Each update occupies the read port for 1 cycle. Sustained throughput is 1 update per cycle.
- Asserting reset mid-sweep or mid-update aborts immediately. Queue contents and any in-flight write are discarded, and the sweep restarts from 0.
- Lookup starvation of updates is bounded: once the queue is full, the update holds the port every cycle until the queue is not full.

## Structure
- Package `lab4_branch_pht_pkg` holds:
  - The top and update state enums.
  - The `INIT_VAL` default.
  - A `sat_update(counter, taken)` function.
- Sub-module `lab4_branch_pht_upd_queue`: parameterised FIFO with val/rdy enqueue, head peek, pop, full, and empty signals.
- The scheduler contains the FSMs, arbiter and forwarding mux only.

## Test plan
- Reset, then idle for PHT_SIZE=16 cycles: `pht_wen` is high for 16 cycles with addresses 0..15 and data 01; `init_done` rises in cycle 16; `pred_rdy` stays 0 before that.
- After init, two taken updates to PC 0x40 back-to-back, then a lookup 4 cycles later: the writes are 10 then 11 (second write uses forwarded data), and the lookup gives `pred_taken=1`.
- Lookup to PC 0x40 in the same cycle as a write to index 0x10: `pred_taken` reflects the old counter 01, giving 0.
- Continuous `pred_val=1` plus 4 updates: the updates wait until the queue is full, then `pred_rdy` drops to 0 and updates drain.
- Not-taken updates on a counter at 00: the written value stays 00. Taken updates on a counter at 11: the written value stays 11.
- Assert reset mid-sweep at counter 7 with 2 queued updates: the queue empties, `upd_rdy=1`, and the sweep restarts at address 0.
